// File: rtl/corr_pkt_decoder.sv
// Correlator record sink: reassembles 5-byte BytePipe packets into parallel fields,
// checks window-number continuity and keeps saturating drop/truncation totals.
module corr_pkt_decoder #(
   parameter int unsigned TIMEOUT_W  = 16,
   parameter int unsigned ERRCOUNT_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cg,
   input  logic                  i_flush,
   input  logic [TIMEOUT_W-1:0]  i_timeoutCycles,
   input  logic [7:0]            i_bp_data,
   input  logic                  i_bp_valid,
   output logic                  o_bp_ready,
   output logic [7:0]            o_pkt_winNum,
   output logic [7:0]            o_pkt_countX,
   output logic [7:0]            o_pkt_countY,
   output logic [7:0]            o_pkt_countIsect,
   output logic [7:0]            o_pkt_countSymdiff,
   output logic [7:0]            o_pkt_gap,
   output logic                  o_pkt_valid,
   input  logic                  i_pkt_ready,
   output logic [ERRCOUNT_W-1:0] o_dropCount,
   output logic [ERRCOUNT_W-1:0] o_truncCount
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIELD = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [2:0]            idx;
   logic [2:0]            idx_next;
   logic [TIMEOUT_W-1:0]  timer;
   logic [TIMEOUT_W:0]    timer_inc;
   logic                  xfer;
   logic                  last_xfer;
   logic                  timeout_hit;
   logic                  abort;
   logic [7:0]            last_win;
   logic                  first_seen;
   logic [7:0]            gap_calc;
   logic [ERRCOUNT_W+7:0] drop_sum;
   logic [ERRCOUNT_W-1:0] drop_next;

   assign o_bp_ready  = (state != HOLD) && !i_flush;
   assign o_pkt_valid = (state == HOLD);
   assign xfer        = i_bp_valid && o_bp_ready && i_cg;
   assign last_xfer   = xfer && (state == FIELD) && (idx == 3'd4);

   // timer holds idle FIELD cycles minus one, so expiry lands on the edge ending cycle t+N
   assign timer_inc   = {1'b0, timer} + {{TIMEOUT_W{1'b0}}, 1'b1};
   assign timeout_hit = (i_timeoutCycles != '0) && (timer_inc == {1'b0, i_timeoutCycles});

   always_comb begin
      state_next = state;
      idx_next   = idx;
      abort      = 1'b0;
      if (i_flush) begin
         state_next = IDLE;
         idx_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  state_next = FIELD;
                  idx_next   = 3'd1;
               end
            end
            FIELD: begin
               if (xfer) begin
                  if (idx == 3'd4) begin
                     state_next = HOLD;
                     idx_next   = '0;
                  end else begin
                     idx_next = idx + 3'd1;
                  end
               end else if (timeout_hit) begin
                  state_next = IDLE;
                  idx_next   = '0;
                  abort      = 1'b1;
               end
            end
            HOLD: begin
               idx_next = '0;
               if (i_pkt_ready) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
               idx_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         idx   <= '0;
         timer <= '0;
      end else if (i_cg) begin
         state <= state_next;
         idx   <= idx_next;
         if (i_flush || (state != FIELD) || xfer || abort) begin
            timer <= '0;
         end else begin
            timer <= timer_inc[TIMEOUT_W-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_pkt_winNum       <= '0;
         o_pkt_countX       <= '0;
         o_pkt_countY       <= '0;
         o_pkt_countIsect   <= '0;
         o_pkt_countSymdiff <= '0;
      end else if (xfer) begin
         case (state)
            IDLE: o_pkt_winNum <= i_bp_data;
            FIELD: begin
               case (idx)
                  3'd1:    o_pkt_countX       <= i_bp_data;
                  3'd2:    o_pkt_countY       <= i_bp_data;
                  3'd3:    o_pkt_countIsect   <= i_bp_data;
                  3'd4:    o_pkt_countSymdiff <= i_bp_data;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      gap_calc = '0;
      if (first_seen) begin
         gap_calc = o_pkt_winNum - (last_win + 8'd1);
      end
      drop_sum  = {8'd0, o_dropCount} + {{ERRCOUNT_W{1'b0}}, gap_calc};
      drop_next = drop_sum[ERRCOUNT_W-1:0];
      if (drop_sum[ERRCOUNT_W+7:ERRCOUNT_W] != 8'd0) begin
         drop_next = '1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_win    <= '0;
         first_seen  <= 1'b0;
         o_pkt_gap   <= '0;
         o_dropCount <= '0;
      end else if (i_cg) begin
         if (i_flush) begin
            first_seen <= 1'b0;
         end else if (last_xfer) begin
            last_win    <= o_pkt_winNum;
            first_seen  <= 1'b1;
            o_pkt_gap   <= gap_calc;
            o_dropCount <= drop_next;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_truncCount <= '0;
      end else if (i_cg && abort && (o_truncCount != '1)) begin
         o_truncCount <= o_truncCount + {{(ERRCOUNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_corr_pkt_decoder.sv
// Directed bench for corr_pkt_decoder: hand-computed packet fields, gaps and counter totals.
module tb_corr_pkt_decoder;

   logic        clk;
   logic        rst;
   logic        cg;
   logic        flush;
   logic [15:0] tmo;
   logic [7:0]  bp_data;
   logic        bp_valid;
   logic        bp_ready;
   logic [7:0]  pkt_win;
   logic [7:0]  pkt_x;
   logic [7:0]  pkt_y;
   logic [7:0]  pkt_i;
   logic [7:0]  pkt_s;
   logic [7:0]  pkt_gap;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [7:0]  drop_cnt;
   logic [7:0]  trunc_cnt;

   int n_asserts = 0;
   int n_fail    = 0;

   corr_pkt_decoder #(
      .TIMEOUT_W  (16),
      .ERRCOUNT_W (8)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_cg               (cg),
      .i_flush            (flush),
      .i_timeoutCycles    (tmo),
      .i_bp_data          (bp_data),
      .i_bp_valid         (bp_valid),
      .o_bp_ready         (bp_ready),
      .o_pkt_winNum       (pkt_win),
      .o_pkt_countX       (pkt_x),
      .o_pkt_countY       (pkt_y),
      .o_pkt_countIsect   (pkt_i),
      .o_pkt_countSymdiff (pkt_s),
      .o_pkt_gap          (pkt_gap),
      .o_pkt_valid        (pkt_valid),
      .i_pkt_ready        (pkt_ready),
      .o_dropCount        (drop_cnt),
      .o_truncCount       (trunc_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one byte and returns at posedge+1 of the cycle after it transferred.
   task automatic send_byte(input logic [7:0] b);
      int unsigned n;
      logic        took;
      n        = 0;
      took     = 1'b0;
      bp_data  = b;
      bp_valid = 1'b1;
      while (!took && n < 50) begin
         #1;
         took = bp_ready && cg;
         @(posedge clk);
         #1;
         n++;
      end
      check("byte_accept", {31'd0, took}, 32'd1);
      bp_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] w, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] i, input logic [7:0] s);
      send_byte(w);
      send_byte(x);
      send_byte(y);
      send_byte(i);
      send_byte(s);
   endtask

   task automatic check_pkt(input string tag, input logic [7:0] w, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] i, input logic [7:0] s,
                            input logic [7:0] gap, input logic [7:0] drop);
      check({tag, "_valid"}, {31'd0, pkt_valid}, 32'd1);
      check({tag, "_win"}, {24'd0, pkt_win}, {24'd0, w});
      check({tag, "_x"}, {24'd0, pkt_x}, {24'd0, x});
      check({tag, "_y"}, {24'd0, pkt_y}, {24'd0, y});
      check({tag, "_isect"}, {24'd0, pkt_i}, {24'd0, i});
      check({tag, "_symdiff"}, {24'd0, pkt_s}, {24'd0, s});
      check({tag, "_gap"}, {24'd0, pkt_gap}, {24'd0, gap});
      check({tag, "_drop"}, {24'd0, drop_cnt}, {24'd0, drop});
   endtask

   task automatic accept_pkt(input string tag);
      pkt_ready = 1'b1;
      tick(1);
      pkt_ready = 1'b0;
      check({tag, "_released"}, {31'd0, pkt_valid}, 32'd0);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      #1;
      check("flush_ready_low", {31'd0, bp_ready}, 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      bp_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cg        = 1'b1;
      flush     = 1'b0;
      tmo       = 16'd0;
      bp_data   = 8'h00;
      bp_valid  = 1'b0;
      pkt_ready = 1'b0;
      #12;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // reset state
      check("rst_valid", {31'd0, pkt_valid}, 32'd0);
      check("rst_ready", {31'd0, bp_ready}, 32'd1);
      check("rst_drop", {24'd0, drop_cnt}, 32'd0);
      check("rst_trunc", {24'd0, trunc_cnt}, 32'd0);
      check("rst_win", {24'd0, pkt_win}, 32'd0);

      // 1: basic stream, valid only after the fifth byte
      send_byte(8'h07);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check("t1_valid_early", {31'd0, pkt_valid}, 32'd0);
      send_byte(8'h44);
      check_pkt("t1", 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00);
      tick(2);
      check("t1_hold_ready", {31'd0, bp_ready}, 32'd0);
      check("t1_hold_valid", {31'd0, pkt_valid}, 32'd1);
      accept_pkt("t1");

      // 2: gaps and wrap; flush first so continuity restarts
      do_flush();
      send_pkt(8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
      check_pkt("t2a", 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00);
      accept_pkt("t2a");
      send_pkt(8'h09, 8'h05, 8'h06, 8'h07, 8'h08);
      check_pkt("t2b", 8'h09, 8'h05, 8'h06, 8'h07, 8'h08, 8'h03, 8'h03);
      accept_pkt("t2b");
      send_pkt(8'hFF, 8'h10, 8'h20, 8'h30, 8'h40);
      check_pkt("t2c", 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'hF5, 8'd248);
      accept_pkt("t2c");
      send_pkt(8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
      check_pkt("t2wrap", 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'd248);
      accept_pkt("t2wrap");

      // 3: timeout after two bytes, expiry exactly N cycles after the last transfer
      tmo = 16'd4;
      send_byte(8'h77);
      send_byte(8'h01);
      tick(3);
      check("t3_not_yet", {24'd0, trunc_cnt}, 32'd0);
      tick(1);
      check("t3_trunc", {24'd0, trunc_cnt}, 32'd1);
      send_pkt(8'h01, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
      check_pkt("t3_after", 8'h01, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h00, 8'd248);
      accept_pkt("t3_after");
      // transfer on the expiry cycle wins
      send_byte(8'h02);
      tick(3);
      send_byte(8'hC1);
      send_byte(8'hC2);
      send_byte(8'hC3);
      send_byte(8'hC4);
      check("t3_race_trunc", {24'd0, trunc_cnt}, 32'd1);
      check_pkt("t3_race", 8'h02, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'd248);

      // 4: backpressure in HOLD with upstream valid held high
      bp_data  = 8'h03;
      bp_valid = 1'b1;
      tick(10);
      check("t4_ready_low", {31'd0, bp_ready}, 32'd0);
      check_pkt("t4_stable", 8'h02, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'd248);
      pkt_ready = 1'b1;
      tick(1);
      pkt_ready = 1'b0;
      check("t4_released", {31'd0, pkt_valid}, 32'd0);
      check("t4_ready_back", {31'd0, bp_ready}, 32'd1);
      send_pkt(8'h03, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
      check_pkt("t4_next", 8'h03, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h00, 8'd248);
      accept_pkt("t4_next");

      // 5: flush mid-packet clears continuity only
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      bp_data  = 8'hDD;
      bp_valid = 1'b1;
      do_flush();
      check("t5_drop_kept", {24'd0, drop_cnt}, 32'd248);
      send_pkt(8'h50, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
      check_pkt("t5a", 8'h50, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'h00, 8'd248);
      accept_pkt("t5a");
      send_pkt(8'h52, 8'hF1, 8'hF2, 8'hF3, 8'hF4);
      check_pkt("t5b", 8'h52, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'h01, 8'd249);
      accept_pkt("t5b");
      check("t5_trunc_kept", {24'd0, trunc_cnt}, 32'd1);

      // 6: drop saturation, then clock-gate freeze
      send_pkt(8'h60, 8'h11, 8'h12, 8'h13, 8'h14);
      check_pkt("t6_sat", 8'h60, 8'h11, 8'h12, 8'h13, 8'h14, 8'h0D, 8'd255);
      accept_pkt("t6_sat");
      send_pkt(8'h70, 8'h21, 8'h22, 8'h23, 8'h24);
      check_pkt("t6_sat2", 8'h70, 8'h21, 8'h22, 8'h23, 8'h24, 8'h0F, 8'd255);
      accept_pkt("t6_sat2");
      send_byte(8'h71);
      send_byte(8'h01);
      cg       = 1'b0;
      bp_data  = 8'hEE;
      bp_valid = 1'b1;
      tick(8);
      cg       = 1'b1;
      bp_valid = 1'b0;
      tick(2);
      check("t6_cg_timer_frozen", {24'd0, trunc_cnt}, 32'd1);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      check_pkt("t6_cg", 8'h71, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'd255);
      accept_pkt("t6_cg");

      // truncation counter saturation
      tmo = 16'd1;
      for (int unsigned k = 0; k < 260; k++) begin
         send_byte(8'h99);
         tick(1);
      end
      check("t6_trunc_sat", {24'd0, trunc_cnt}, 32'd255);
      check("t6_drop_sat_kept", {24'd0, drop_cnt}, 32'd255);

      // asynchronous reset while a packet is held
      tmo = 16'd0;
      send_pkt(8'h80, 8'h31, 8'h32, 8'h33, 8'h34);
      check_pkt("t7_held", 8'h80, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0E, 8'd255);
      #2;
      rst = 1'b1;
      #1;
      check("t7_rst_valid", {31'd0, pkt_valid}, 32'd0);
      check("t7_rst_win", {24'd0, pkt_win}, 32'd0);
      check("t7_rst_drop", {24'd0, drop_cnt}, 32'd0);
      check("t7_rst_trunc", {24'd0, trunc_cnt}, 32'd0);
      check("t7_rst_gap", {24'd0, pkt_gap}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("t7_ready_after", {31'd0, bp_ready}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
